// File: rtl/rdseed_buffer.sv
// rdseed_buffer: seed FIFO between the conditioner and the core RDSEED port.
// Accepts DATA_WIDTH-bit seeds, serves them as OUT_WIDTH-bit slots with a
// carry flag for underflow, and zeroizes every slot as it is handed out.
module rdseed_buffer #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned OUT_WIDTH  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         seed_valid_i,
    output logic                         seed_ready_o,
    input  logic [DATA_WIDTH-1:0]        seed_i,
    input  logic                         req_i,
    input  logic [1:0]                   req_width_i,
    output logic                         resp_valid_o,
    output logic [OUT_WIDTH-1:0]         resp_data_o,
    output logic                         resp_cf_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned SLOTS = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned BW    = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [SW-1:0]         slot;
    logic [CW-1:0]         count;

    logic                  push;
    logic                  pop;
    logic                  last_slot;
    logic [BW-1:0]         base;
    logic [OUT_WIDTH-1:0]  slot_word;
    logic [OUT_WIDTH-1:0]  served;

    // Status flags come straight from the registered occupancy count.
    assign count_o      = count;
    assign empty_o      = (count == '0);
    assign full_o       = (count == CW'(DEPTH));
    assign seed_ready_o = !full_o;

    // Handshake decode and selection/masking of the slot being served.
    always_comb begin
        push      = seed_valid_i && !full_o;
        pop       = req_i && (count != '0);
        last_slot = (slot == SW'(SLOTS - 1));
        base      = BW'(slot) * BW'(OUT_WIDTH);
        slot_word = mem[rd_ptr][base +: OUT_WIDTH];
        served    = '0;
        unique case (req_width_i)
            2'b00:   served[15:0] = slot_word[15:0];
            2'b01:   served[31:0] = slot_word[31:0];
            default: served       = slot_word;
        endcase
    end

    // Seed storage: clear on reset, zeroize the served slot, write pushed seeds.
    // A push never targets the entry being drained (that would need full), so
    // the two writes cannot collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                mem[rd_ptr][base +: OUT_WIDTH] <= '0;
            end
            if (push) begin
                mem[wr_ptr] <= seed_i;
            end
        end
    end

    // Pointer, slot index and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            slot   <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                if (last_slot) begin
                    slot   <= '0;
                    rd_ptr <= rd_ptr + PW'(1);
                end else begin
                    slot <= slot + SW'(1);
                end
            end
            unique case ({push, pop && last_slot})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered response: one strobe per request, data/cf held between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_cf_o    <= 1'b0;
        end else begin
            resp_valid_o <= req_i;
            if (req_i) begin
                resp_data_o <= pop ? served : '0;
                resp_cf_o   <= pop;
            end
        end
    end

endmodule
